controlador_display: RTL and testbench



---
 rtl/controlador_display.sv | 181 ++++++++++++++++++
 tb/tb_controlador_display.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_display.sv
// controlador_display: 11-bit binary to 4-digit BCD (shift-add-3)
// and multiplexed common-anode 7-segment driver. Optional macro:
// CEROS_IZQ_EN enables leading-zero blanking on digits 3..1.
module controlador_display #(
   parameter int CLK_HZ     = 27000000,
   parameter int REFRESH_HZ = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] valor,
   input  logic        cargar,
   output logic        ocupado,
   output logic        listo,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int PRE_RAW = CLK_HZ / REFRESH_HZ;
   localparam int PRE     = (PRE_RAW < 1) ? 1 : PRE_RAW;
   localparam int PW      = (PRE > 1) ? $clog2(PRE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } estado_t;

   estado_t       r_estado;
   logic [10:0]   r_sr;
   logic [15:0]   r_bcd;
   logic [3:0]    r_cnt;
   logic          r_ocupado;
   logic          r_listo;
   logic [15:0]   r_dig;
   logic [3:0]    r_blank;
   logic [PW-1:0] r_pre;
   logic [1:0]    r_idx;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;

   logic [15:0]   w_adj;
   logic [15:0]   w_bcd_nx;
   logic [10:0]   w_sr_nx;
   logic [3:0]    w_blank_nx;
   logic          w_pre_fin;
   logic [1:0]    w_idx_nx;
   logic [3:0]    w_dig_sel;
   logic          w_blank_sel;
   logic [6:0]    w_seg_nx;

   // Active-low a..g encoding; anything above 9 is blank.
   function automatic logic [6:0] f_enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Add-3 correction on every BCD nibble that is 5 or more.
   always_comb begin
      w_adj = r_bcd;
      for (int k = 0; k < 4; k++) begin
         if (r_bcd[4*k +: 4] >= 4'd5) begin
            w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
         end
      end
   end

   // One shift-add-3 step: {bcd, sr} shifted left by one.
   always_comb begin
      w_bcd_nx = {w_adj[14:0], r_sr[10]};
      w_sr_nx  = {r_sr[9:0], 1'b0};
   end

`ifdef CEROS_IZQ_EN
   // Blank a digit while it and all higher digits are zero.
   always_comb begin
      w_blank_nx    = 4'b0000;
      w_blank_nx[3] = (w_bcd_nx[15:12] == 4'd0);
      w_blank_nx[2] = w_blank_nx[3] && (w_bcd_nx[11:8] == 4'd0);
      w_blank_nx[1] = w_blank_nx[2] && (w_bcd_nx[7:4] == 4'd0);
   end
`else
   // All four digits always shown.
   always_comb begin
      w_blank_nx = 4'b0000;
   end
`endif

   // Converter FSM; digits and mask are latched as DONE is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado  <= IDLE;
         r_sr      <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_ocupado <= 1'b0;
         r_listo   <= 1'b0;
         r_dig     <= '0;
         r_blank   <= '0;
      end else begin
         case (r_estado)
            IDLE: begin
               r_listo <= 1'b0;
               if (cargar) begin
                  r_sr      <= valor;
                  r_bcd     <= '0;
                  r_cnt     <= 4'd11;
                  r_ocupado <= 1'b1;
                  r_estado  <= CONV;
               end else begin
                  r_ocupado <= 1'b0;
               end
            end
            CONV: begin
               r_bcd <= w_bcd_nx;
               r_sr  <= w_sr_nx;
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_dig    <= w_bcd_nx;
                  r_blank  <= w_blank_nx;
                  r_listo  <= 1'b1;
                  r_estado <= DONE;
               end
            end
            DONE: begin
               r_listo   <= 1'b0;
               r_ocupado <= 1'b0;
               r_estado  <= IDLE;
            end
            default: begin
               r_listo   <= 1'b0;
               r_ocupado <= 1'b0;
               r_estado  <= IDLE;
            end
         endcase
      end
   end

   // Next scan index and the segment pattern it selects.
   always_comb begin
      w_pre_fin   = (r_pre == PRE_MAX);
      w_idx_nx    = w_pre_fin ? 2'(r_idx + 2'd1) : r_idx;
      w_dig_sel   = r_dig[{w_idx_nx, 2'b00} +: 4];
      w_blank_sel = r_blank[w_idx_nx];
      w_seg_nx    = w_blank_sel ? 7'b1111111 : f_enc(w_dig_sel);
   end

   // Scanner: prescaler, digit index and registered an/seg.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre <= '0;
         r_idx <= 2'd0;
         r_an  <= 4'b1110;
         r_seg <= 7'b0000001;
      end else begin
         r_pre <= w_pre_fin ? '0 : PW'(r_pre + 1'b1);
         r_idx <= w_idx_nx;
         r_an  <= ~(4'b0001 << w_idx_nx);
         r_seg <= w_seg_nx;
      end
   end

   assign ocupado = r_ocupado;
   assign listo   = r_listo;
   assign an      = r_an;
   assign seg     = r_seg;

endmodule

// File: tb/tb_controlador_display.sv
// tb_controlador_display: random and directed stimulus checked
// every cycle against a value-level model of the display.
module tb_controlador_display;

   localparam int CLK_HZ     = 8;
   localparam int REFRESH_HZ = 2;
   localparam int P          = CLK_HZ / REFRESH_HZ;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] valor = '0;
   logic        cargar = 1'b0;
   logic        ocupado;
   logic        listo;
   logic [3:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   controlador_display #(
      .CLK_HZ(CLK_HZ),
      .REFRESH_HZ(REFRESH_HZ)
   ) dut (
      .clk(clk),
      .rst(rst),
      .valor(valor),
      .cargar(cargar),
      .ocupado(ocupado),
      .listo(listo),
      .an(an),
      .seg(seg)
   );

   function automatic logic [6:0] enc(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input int i);
      int p;
      p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
`ifdef CEROS_IZQ_EN
      if (i > 0 && v < p) return 7'b1111111;
`endif
      return enc((v / p) % 10);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: edge count since reset, active conversion, shown value.
   int m_e = 0;
   int m_start = 0;
   int m_shown = 0;
   int m_pend = 0;
   bit m_act = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_e = 0;
         m_act = 1'b0;
         m_start = 0;
         m_shown = 0;
         m_pend = 0;
      end else begin
         m_e++;
         if (m_act && m_e == m_start + 12) begin
            m_shown = m_pend;
            m_act = 1'b0;
         end else if (!m_act && cargar) begin
            m_act = 1'b1;
            m_start = m_e;
            m_pend = int'(valor);
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         int idx;
         logic [3:0] ea;
         idx = (m_e / P) % 4;
         ea = ~(4'b0001 << idx);
         chk("ocupado", 32'(ocupado),
             32'(m_act && (m_e - m_start) <= 11));
         chk("listo", 32'(listo), 32'(m_act && m_e == m_start + 11));
         chk("an", 32'(an), 32'(ea));
         chk("seg", 32'(seg), 32'(exp_seg(m_shown, idx)));
      end
   end

   task automatic load(input int v);
      @(negedge clk);
      valor = 11'(v);
      cargar = 1'b1;
      @(negedge clk);
      cargar = 1'b0;
   endtask

   // Walk the four digits, checking literal segment patterns.
   task automatic scan(input string nm, input logic [27:0] e);
      for (int i = 0; i < 4; i++) begin
         int t;
         logic [3:0] ta;
         ta = ~(4'b0001 << i);
         t = 0;
         while (an !== ta && t < 40) begin
            @(negedge clk);
            t++;
         end
         if (t >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout act=%0h exp=%0h", nm, an, ta);
         end else begin
            chk(nm, 32'(seg), 32'(e[7*i +: 7]));
         end
      end
   endtask

   initial begin
      int no;
      int nl;
      logic [6:0] z;
`ifdef CEROS_IZQ_EN
      z = 7'b1111111;
`else
      z = 7'b0000001;
`endif
      repeat (2) @(negedge clk);
      chk("rst_an", 32'(an), 32'(4'b1110));
      chk("rst_seg", 32'(seg), 32'(7'b0000001));
      chk("rst_ocupado", 32'(ocupado), 32'(0));
      chk("rst_listo", 32'(listo), 32'(0));
      rst = 1'b0;
      repeat (3) @(negedge clk);

      load(1998);
      no = 0;
      nl = 0;
      for (int k = 0; k < 20; k++) begin
         if (ocupado) no++;
         if (listo) nl++;
         @(negedge clk);
      end
      chk("ocupado_cycles", 32'(no), 32'(12));
      chk("listo_pulses", 32'(nl), 32'(1));
      scan("d1998", {7'b1001111, 7'b0000100, 7'b0000100, 7'b0000000});

      load(5);
      repeat (15) @(negedge clk);
      scan("d5", {z, z, z, 7'b0100100});

      load(1234);
      nl = 0;
      for (int k = 0; k < 20; k++) begin
         if (listo) nl++;
         if (k == 4 || k == 11) begin
            valor = 11'd2047;
            cargar = 1'b1;
         end else begin
            cargar = 1'b0;
         end
         @(negedge clk);
      end
      chk("busy_listo", 32'(nl), 32'(1));
      scan("d1234", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});

      load(999);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_ocupado", 32'(ocupado), 32'(0));
      chk("mid_listo", 32'(listo), 32'(0));
      chk("mid_an", 32'(an), 32'(4'b1110));
      chk("mid_seg", 32'(seg), 32'(7'b0000001));
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      nl = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (listo) nl++;
      end
      chk("mid_no_listo", 32'(nl), 32'(0));
      scan("d0", {z, z, z, 7'b0000001});

      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         valor = 11'($urandom_range(0, 2047));
         cargar = ($urandom_range(0, 7) == 0);
      end
      cargar = 1'b0;
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
